// File: rtl/cgol_pkg.sv
// Shared Game of Life definitions: board geometry and the seed scanner state encoding.
// The display path and board memory take their dimensions from here as well.
package cgol_pkg;

    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        WRITE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/row_debouncer.sv
// Debounces one strobed row of the switch matrix: accepts a row after STABLE identical
// consecutive samples, or forces an accept after MAXTRY sample cycles.
module row_debouncer #(
    parameter int WIDTH  = cgol_pkg::WIDTH,
    parameter int STABLE = 3,
    parameter int MAXTRY = 255
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] col_in,
    output logic             accept,
    output logic             forced
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int TW = $clog2(MAXTRY + 1);

    logic [WIDTH-1:0] smp;
    logic [CW-1:0]    stable_cnt;
    logic [CW-1:0]    stable_next;
    logic [TW-1:0]    try_cnt;
    logic [TW-1:0]    try_next;
    logic             hit;
    logic             timeout;

    // accept judges the sample being captured on this edge, so the FSM leaves SAMPLE
    // on the same edge that the deciding sample lands in smp.
    always_comb begin
        stable_next = CW'(1);
        if (stable_cnt != '0 && col_in == smp)
            stable_next = stable_cnt + CW'(1);
        try_next = try_cnt + TW'(1);
        hit      = (stable_next >= CW'(STABLE));
        timeout  = (try_next >= TW'(MAXTRY));
        accept   = en && (hit || timeout);
        forced   = en && timeout && !hit;
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge ph1) begin
        if (reset || clear) begin
            smp        <= '0;
            stable_cnt <= '0;
            try_cnt    <= '0;
        end else if (en) begin
            smp        <= col_in;
            stable_cnt <= stable_next;
            try_cnt    <= try_next;
        end
    end

endmodule

// File: rtl/seed_scanner.sv
// Scans the WIDTHxWIDTH seeding switch matrix row by row and writes each debounced row
// into the board memory, holding the generation controller off via busy meanwhile.
module seed_scanner #(
    parameter int WIDTH   = cgol_pkg::WIDTH,
    parameter int REGBITS = cgol_pkg::REGBITS,
    parameter int SETTLE  = 4,
    parameter int STABLE  = 3,
    parameter int MAXTRY  = 255
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   col_in,
    output logic [WIDTH-1:0]   scan_row,
    output logic               we,
    output logic [REGBITS-1:0] waddr,
    output logic [WIDTH-1:0]   wd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import cgol_pkg::*;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ROW0     = WIDTH'(1);

    scan_state_t        state;
    logic [REGBITS-1:0] r;
    logic [REGBITS-1:0] r_next;
    logic [SW-1:0]      settle_cnt;
    logic               accept;
    logic               forced;
    logic               deb_clear;
    logic               deb_en;

    assign r_next    = r + REGBITS'(1);
    assign deb_clear = (state == DRIVE);
    assign deb_en    = (state == SAMPLE);

    row_debouncer #(
        .WIDTH  (WIDTH),
        .STABLE (STABLE),
        .MAXTRY (MAXTRY)
    ) u_debouncer (
        .ph1    (ph1),
        .reset  (reset),
        .clear  (deb_clear),
        .en     (deb_en),
        .col_in (col_in),
        .accept (accept),
        .forced (forced)
    );

    always_ff @(posedge ph1) begin
        if (reset) begin
            state      <= IDLE;
            r          <= '0;
            settle_cnt <= '0;
            scan_row   <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wd         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    scan_row <= '0;
                    we       <= 1'b0;
                    waddr    <= '0;
                    wd       <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        state      <= DRIVE;
                        r          <= '0;
                        settle_cnt <= '0;
                        scan_row   <= ROW0;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        state      <= SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (accept) begin
                        state <= WRITE;
                        we    <= 1'b1;
                        waddr <= r;
                        wd    <= col_in;
                        if (forced)
                            err <= 1'b1;
                    end
                end
                WRITE: begin
                    we <= 1'b0;
                    if (r == LAST_ROW) begin
                        state    <= DONE;
                        scan_row <= '0;
                        done     <= 1'b1;
                    end else begin
                        state      <= DRIVE;
                        r          <= r_next;
                        settle_cnt <= '0;
                        scan_row   <= ROW0 << r_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    waddr <= '0;
                    wd    <= '0;
                end
                default: begin
                    state    <= IDLE;
                    scan_row <= '0;
                    we       <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seed_scanner.sv
// Self-checking bench for seed_scanner: a bouncing switch-matrix model drives col_in from
// the strobed row, and a row-by-row debounce model predicts every write and the done cycle.
module tb_seed_scanner;

    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;
    localparam int SETTLE  = 4;
    localparam int STABLE  = 3;
    localparam int MAXTRY  = 255;
    localparam int NLEN    = 512;
    localparam int TIMEOUT = WIDTH * (SETTLE + MAXTRY + 2) + 20;

    logic               ph1 = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   col_in;
    logic [WIDTH-1:0]   scan_row;
    logic               we;
    logic [REGBITS-1:0] waddr;
    logic [WIDTH-1:0]   wd;
    logic               busy;
    logic               done;
    logic               err;

    seed_scanner #(
        .WIDTH   (WIDTH),
        .REGBITS (REGBITS),
        .SETTLE  (SETTLE),
        .STABLE  (STABLE),
        .MAXTRY  (MAXTRY)
    ) dut (
        .ph1      (ph1),
        .reset    (reset),
        .start    (start),
        .col_in   (col_in),
        .scan_row (scan_row),
        .we       (we),
        .waddr    (waddr),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 ph1 = ~ph1;

    // Edge counter: edge n sets cyc to n; the period following edge n is cycle n+1.
    int cyc = 0;
    always @(posedge ph1) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Switch matrix: row r reads noise[r][c] for c < blen[r] cycles after its strobe
    // rises, and the pressed-key pattern keys[r] after that.
    logic [WIDTH-1:0] keys  [WIDTH];
    int               blen  [WIDTH];
    logic [WIDTH-1:0] noise [WIDTH][NLEN];

    function automatic logic [WIDTH-1:0] colval(input int r, input int c);
        if (c < blen[r])
            return noise[r][c];
        return keys[r];
    endfunction

    function automatic int row_of(input logic [WIDTH-1:0] s);
        for (int i = 0; i < WIDTH; i++)
            if (s[i]) return i;
        return 0;
    endfunction

    initial begin : matrix_driver
        int               age;
        logic [WIDTH-1:0] prev;
        age    = 0;
        prev   = '0;
        col_in = '0;
        forever begin
            @(negedge ph1);
            if (scan_row != prev) age = 0;
            else                  age++;
            prev = scan_row;
            if (scan_row == '0) col_in = WIDTH'($urandom);
            else                col_in = colval(row_of(scan_row), age);
        end
    end

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;
    wr_t wq[$];

    initial begin : write_monitor
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge ph1);
            if (we) begin
                wq.push_back('{cyc + 1, int'(waddr), int'(wd)});
                check("we_single_cycle", 32'(prev_we), 32'd0);
            end
            prev_we = we;
        end
    end

    // Reference: each row is strobed, settles SETTLE cycles, then is sampled until STABLE
    // equal samples in a row or MAXTRY samples; the write takes the cycle after that.
    int               exp_cyc  [WIDTH];
    logic [WIDTH-1:0] exp_data [WIDTH];
    int               exp_done;
    bit               exp_err;

    task automatic model_scan(input int k);
        int t;
        t       = k + 1;
        exp_err = 1'b0;
        for (int r = 0; r < WIDTH; r++) begin
            int               n, run;
            bit               acc;
            logic [WIDTH-1:0] v, prev;
            n = 0; run = 0; acc = 1'b0; v = '0; prev = '0;
            while (!acc && n < MAXTRY) begin
                v   = colval(r, SETTLE + n);
                n++;
                run = (n > 1 && v == prev) ? run + 1 : 1;
                prev = v;
                acc = (run >= STABLE);
            end
            if (!acc) exp_err = 1'b1;
            exp_cyc[r]  = t + SETTLE + n;
            exp_data[r] = v;
            t = exp_cyc[r] + 1;
        end
        exp_done = t;
    endtask

    // Starts a scan sampled at edge k, optionally poking start while busy, and checks it.
    task automatic run_scan(input int k, input bit poke, output int dcyc);
        int t;
        bit got;
        wq.delete();
        do @(negedge ph1); while (cyc < k - 1);
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_on_start", 32'(err), 32'd0);
        check("row0_strobe", 32'(scan_row), 32'd1);
        model_scan(k);
        got = 1'b0; t = 0; dcyc = 0;
        while (!got && t < TIMEOUT) begin
            @(negedge ph1);
            #1;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc + 1;
            end else begin
                start = poke && ($urandom_range(0, 7) == 0);
            end
            t++;
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("done_cycle", dcyc, exp_done);
        check("done_strobe_off", 32'(scan_row), 32'd0);
        check("write_count", wq.size(), WIDTH);
        for (int i = 0; i < WIDTH && i < wq.size(); i++) begin
            check($sformatf("waddr_%0d", i), wq[i].addr, i);
            check($sformatf("wd_%0d", i), wq[i].data, 32'(exp_data[i]));
            check($sformatf("we_cycle_%0d", i), wq[i].cyc, exp_cyc[i]);
        end
        @(negedge ph1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("err_after_scan", 32'(err), 32'(exp_err));
    endtask

    task automatic set_clean();
        for (int r = 0; r < WIDTH; r++) begin
            keys[r] = WIDTH'($urandom);
            blen[r] = 0;
        end
    endtask

    initial begin : main
        int d;
        int t;
        int nw;
        logic [WIDTH-1:0] v;

        reset = 1'b1;
        start = 1'b0;
        set_clean();
        repeat (3) @(negedge ph1);
        check("rst_scan_row", 32'(scan_row), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wd", 32'(wd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Clean row-dependent pattern, start sampled at edge 10.
        for (int r = 0; r < WIDTH; r++) keys[r] = WIDTH'(1) << r;
        run_scan(10, 1'b0, d);
        check("done_at_75", d, 75);

        // Row 3 bounces AA/55 for its first two samples, then settles at 3C.
        set_clean();
        keys[3] = 8'h3C;
        blen[3] = SETTLE + 2;
        for (int c = 0; c < SETTLE; c++) noise[3][c] = WIDTH'($urandom);
        noise[3][SETTLE]     = 8'hAA;
        noise[3][SETTLE + 1] = 8'h55;
        run_scan(cyc + 3, 1'b1, d);
        if (wq.size() == WIDTH) begin
            check("row3_data_3c", wq[3].data, 32'h3C);
            check("row3_delay", wq[3].cyc - wq[2].cyc, SETTLE + STABLE + 1 + 2);
        end

        // Row 5 never settles: forced accept of the last sample and a sticky err.
        set_clean();
        blen[5] = NLEN;
        noise[5][0] = WIDTH'($urandom);
        for (int c = 1; c < NLEN; c++) begin
            v = WIDTH'($urandom);
            if (v == noise[5][c - 1]) v = v ^ WIDTH'(1);
            noise[5][c] = v;
        end
        run_scan(cyc + 3, 1'b0, d);
        check("forced_err", 32'(err), 32'd1);
        if (wq.size() == WIDTH)
            check("row5_last_sample", wq[5].data, 32'(noise[5][SETTLE + MAXTRY - 1]));
        repeat (5) @(negedge ph1);
        check("err_sticky_idle", 32'(err), 32'd1);

        // Random bounce patterns with start pokes while busy.
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < WIDTH; r++) begin
                keys[r] = WIDTH'($urandom);
                blen[r] = $urandom_range(0, 14);
                for (int c = 0; c < blen[r]; c++)
                    noise[r][c] = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : keys[r];
            end
            run_scan(cyc + 2 + $urandom_range(0, 5), 1'b1, d);
        end

        // Reset during row 4's SAMPLE phase.
        set_clean();
        @(negedge ph1);
        wq.delete();
        start = 1'b1;
        @(negedge ph1);
        start = 1'b0;
        t = 0;
        while (wq.size() < 4 && t < TIMEOUT) begin
            @(negedge ph1);
            t++;
        end
        check("reached_row4", wq.size(), 4);
        repeat (SETTLE + 2) @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        reset = 1'b0;
        check("midrst_scan_row", 32'(scan_row), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        nw = wq.size();
        repeat (30) @(negedge ph1);
        check("midrst_no_writes", wq.size(), nw);
        check("midrst_still_idle", 32'(busy), 32'd0);

        // start together with reset: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(negedge ph1);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge ph1);
        check("rst_start_idle_busy", 32'(busy), 32'd0);
        check("rst_start_idle_strobe", 32'(scan_row), 32'd0);

        // Recovery scan after the resets.
        set_clean();
        run_scan(cyc + 3, 1'b1, d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seed_scanner.md
# seed_scanner

Reads an initial Game of Life pattern from a WIDTH×WIDTH push-button/switch matrix and writes it row by row into the board state memory. It is the input-side counterpart of the display path: the display controller drives row/column lines outward from stored state, while this block drives row strobes outward and senses column lines inward to produce state. It sits between the pad ring and the board memory write port, and holds the generation controller off while seeding.

## Interface
Parameters:
- WIDTH, 8, board dimension and the number of row strobes/column senses.
- REGBITS, 3, row address width; log2(WIDTH).
- SETTLE, 4, cycles a row strobe is held before sampling begins; must be at least 1.
- STABLE, 3, consecutive identical column samples required to accept a row; must be at least 1.
- MAXTRY, 255, sample-cycle limit per row before a forced accept.

Ports:
- ph1  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a scan.
- col_in  in  WIDTH  column sense lines, active-high; already synchronised externally.
- scan_row  out  WIDTH  one-hot row strobe, active-high.
- we  out  1  board memory write enable.
- waddr  out  REGBITS  board row address.
- wd  out  WIDTH  row data; bit j = col_in[j].
- busy  out  1  scan in progress; the controller freezes generation updates while this is high.
- done  out  1  one-cycle pulse after the last row is written.
- err  out  1  sticky; set on any forced accept.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, WRITE, DONE.
- IDLE: all outputs 0 except err, which holds its value. start=1 → DRIVE with r=0, and err is cleared.
- DRIVE: scan_row = 1<<r. Settle counter runs for exactly SETTLE cycles, then the FSM moves to SAMPLE.
- SAMPLE: scan_row is held. Each cycle col_in is captured into smp.
  - If it equals the previous sample, stable_cnt increments; otherwise stable_cnt is set to 1. The first sample sets stable_cnt to 1.
  - When stable_cnt reaches STABLE → WRITE.
  - If the sample-cycle count reaches MAXTRY first → WRITE with the latest sample, and err is set.
- WRITE: one cycle with we=1, waddr=r, wd=smp, scan_row still driven.
  - If r==WIDTH-1 → DONE.
  - Otherwise r increments and the FSM returns to DRIVE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- busy=1 in all states except IDLE.
- start is ignored while busy.
- Row counter arithmetic is REGBITS wide. There is no wrap-around, because termination occurs at WIDTH-1.
- scan_row is zero in IDLE and DONE.

## Timing
- Reset values: state=IDLE, scan_row=0, we=0, waddr=0, wd=0, busy=0, done=0, err=0, all counters 0.
- Reset mid-scan: the next edge returns to IDLE with the reset values above. Rows already written stay in memory; no further writes occur.
- Reset and start in the same cycle: reset wins.
- Start latency: start sampled at edge k → DRIVE of row 0, and busy=1, from cycle k+1.
- Clean (bounce-free) input: each row takes SETTLE + STABLE + 1 cycles. First we appears at cycle k+1+SETTLE+STABLE.
- Clean-input total: done at cycle k+1+WIDTH·(SETTLE+STABLE+1). With defaults this is k+65.
- A col_in change during SAMPLE resets stable_cnt to 1. Each such change extends the row by up to STABLE−1 cycles, bounded by MAXTRY.
- we is never asserted for more than one consecutive cycle.

## Structure
- Shared package cgol_pkg holds:
  - the state enum scan_state_t (IDLE, DRIVE, SAMPLE, WRITE, DONE);
  - the board dimension constants WIDTH and REGBITS, which are also used by the display path and the board memory.
- One sub-module, row_debouncer, is natural. It contains the sample register, stable_cnt, the try counter and the accept/forced outputs, and its clear is driven by the FSM on DRIVE entry.
- The FSM, settle counter, row counter and output registers live in seed_scanner.

## Test plan
- Reset then start at cycle 10, with col_in tied to a row-dependent pattern (row r presents 8'h01<<r) → eight writes: addr 0..7 with data 01,02,04,…,80; done at cycle 75; err=0.
- col_in toggles 8'hAA/8'h55 for 2 cycles at the start of row 3's SAMPLE, then settles at 8'h3C → row 3 is written as 3C, its write is delayed 2 cycles, and err=0.
- col_in toggles every cycle for the whole of row 5 → forced accept after 255 sample cycles, the last sample is written at addr 5, and err=1 until the next start.
- Assert reset during row 4's SAMPLE → the next cycle shows scan_row=0, busy=0, and no further we.
- Pulse start again while busy → ignored, with no change to r or timing. start in the same cycle as reset → remains IDLE.
